// File: rtl/ulx3s_pll_reset_seq.sv
// PLL reset/lock supervisor for the ULX3S: pulses the PLL reset, waits for a stable lock,
// then releases the three output-domain resets one by one. Optional macro: PLL_RETRY_LIMIT_EN.
module ulx3s_pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 256,
    parameter int STAGGER       = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic [2:0] dom_resetn,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retries,
    output logic [2:0] debug_state
);

    localparam int REL_LAST = 2 * STAGGER;
    localparam int MAX_A    = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int MAX_B    = (STABLE_CYCLES > REL_LAST) ? STABLE_CYCLES : REL_LAST;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STG      = CW'(STAGGER);
    localparam logic [CW-1:0] STG2     = CW'(REL_LAST);

    typedef enum logic [2:0] {
        S_PRST    = 3'd0,
        S_WLOCK   = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          low_seen, low_seen_next;
    logic [3:0]    retries_next;
    logic          rst_meta, rst_ok;
    logic          lk_meta, lk_s;
    logic          pll_rst_d, ready_d;
    logic [2:0]    dom_d;

    // Reset-release and lock synchronizers; both clear immediately on resetn.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            rst_meta <= 1'b0;
            rst_ok   <= 1'b0;
            lk_meta  <= 1'b0;
            lk_s     <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_ok   <= rst_meta;
            lk_meta  <= pll_locked;
            lk_s     <= lk_meta;
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state    <= S_PRST;
            cnt      <= '0;
            low_seen <= 1'b0;
            retries  <= 4'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            low_seen <= low_seen_next;
            retries  <= retries_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        low_seen_next = 1'b0;
        retries_next  = retries;
        if (restart && state != S_FAIL) begin
            state_next = S_PRST;
            cnt_next   = '0;
        end else begin
            case (state)
                S_PRST: begin
                    // The count may finish during reset synchronization; leaving waits for rst_ok.
                    if (cnt == RST_LAST) begin
                        if (rst_ok) begin
                            state_next = S_WLOCK;
                            cnt_next   = '0;
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_WLOCK: begin
                    if (lk_s) begin
                        // The sample that ends WLOCK is the first of the stable run.
                        state_next = (STABLE_CYCLES == 1) ? S_RELEASE : S_STABLE;
                        cnt_next   = (STABLE_CYCLES == 1) ? '0 : CW'(1);
                    end else if (cnt == TO_LAST) begin
                        retries_next = (retries == 4'd15) ? retries : retries + 4'd1;
                        cnt_next     = '0;
                        state_next   = S_PRST;
`ifdef PLL_RETRY_LIMIT_EN
                        if (int'(retries_next) == MAX_RETRIES) state_next = S_FAIL;
`endif
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_STABLE: begin
                    if (!lk_s) begin
                        state_next = S_WLOCK;
                        cnt_next   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_next = S_RELEASE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_RELEASE, S_RUN: begin
                    // Only a second consecutive low sample counts as a real lock loss.
                    if (!lk_s && low_seen) begin
                        state_next = S_PRST;
                        cnt_next   = '0;
                    end else begin
                        low_seen_next = !lk_s;
                        if (state == S_RELEASE) begin
                            if (cnt == STG2) begin
                                state_next = S_RUN;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt + CW'(1);
                            end
                        end
                    end
                end
                S_FAIL: state_next = S_FAIL;
                default: begin
                    state_next = S_PRST;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    logic fail_d;
`endif

    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        pll_rst_d = 1'b0;
        dom_d     = 3'b000;
        ready_d   = 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
        fail_d    = 1'b0;
`endif
        case (state_next)
            S_PRST:    pll_rst_d = 1'b1;
            S_RELEASE: dom_d = {cnt_next >= STG2, cnt_next >= STG, 1'b1};
            S_RUN: begin
                dom_d   = 3'b111;
                ready_d = 1'b1;
            end
            S_FAIL: begin
                pll_rst_d = 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
                fail_d    = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            pll_rst    <= 1'b1;
            dom_resetn <= 3'b000;
            ready      <= 1'b0;
        end else begin
            pll_rst    <= pll_rst_d;
            dom_resetn <= dom_d;
            ready      <= ready_d;
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) fail <= 1'b0;
        else         fail <= fail_d;
    end
`else
    assign fail = 1'b0;
`endif

    assign debug_state = state;

endmodule
